// File: rtl/text_draw_controller.sv
// Glyph sequencer: buffer read -> pattern encoder -> one VGA pixel per cycle.
// Optional TEXT_TRANSPARENT_EN: plot only lit pixels, leave the background.
module text_draw_controller #(
  parameter int         MAX_CHARS  = 16,
  parameter int         CHAR_PITCH = 4,
  parameter logic [2:0] BG_COLOUR  = 3'b000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [7:0]                   origin_x,
  input  logic [6:0]                   origin_y,
  input  logic [$clog2(MAX_CHARS):0]   num_chars,
  input  logic [2:0]                   colour,
  output logic [$clog2(MAX_CHARS)-1:0] buf_addr,
  input  logic [5:0]                   buf_code,
  output logic [5:0]                   pat_code,
  input  logic [0:14]                  pat_bits,
  output logic [7:0]                   x,
  output logic [6:0]                   y,
  output logic [2:0]                   colour_out,
  output logic                         plot,
  output logic                         busy,
  output logic                         done
);

  localparam int AW = $clog2(MAX_CHARS);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] READ   = 3'd1;
  localparam logic [2:0] LATCH  = 3'd2;
  localparam logic [2:0] DRAW   = 3'd3;
  localparam logic [2:0] FINISH = 3'd4;

  logic [2:0]    state;
  logic [AW-1:0] glyph;
  logic [AW:0]   count;
  logic [AW:0]   nclamp;
  logic [AW:0]   nxt;
  logic [3:0]    k;
  logic [1:0]    col;
  logic [2:0]    row;
  logic [7:0]    xbase;
  logic [6:0]    oy;
  logic [2:0]    fg;

  assign nclamp = (num_chars > (AW+1)'(MAX_CHARS))
                ? (AW+1)'(MAX_CHARS) : num_chars;
  assign nxt = {1'b0, glyph} + {{AW{1'b0}}, 1'b1};

  assign buf_addr = glyph;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      glyph      <= '0;
      count      <= '0;
      k          <= '0;
      col        <= '0;
      row        <= '0;
      xbase      <= '0;
      oy         <= '0;
      fg         <= '0;
      pat_code   <= '0;
      x          <= '0;
      y          <= '0;
      colour_out <= '0;
      plot       <= 1'b0;
      done       <= 1'b0;
    end else begin
      plot <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            xbase <= origin_x;
            oy    <= origin_y;
            fg    <= colour;
            count <= nclamp;
            glyph <= '0;
            k     <= '0;
            col   <= '0;
            row   <= '0;
            state <= (nclamp == '0) ? FINISH : READ;
          end
        end
        READ: state <= LATCH;
        LATCH: begin
          pat_code <= buf_code;
          state    <= DRAW;
        end
        DRAW: begin
          x <= xbase + {6'b0, col};
          y <= oy + {4'b0, row};
`ifdef TEXT_TRANSPARENT_EN
          plot       <= pat_bits[k];
          colour_out <= fg;
`else
          plot       <= 1'b1;
          colour_out <= pat_bits[k] ? fg : BG_COLOUR;
`endif
          if (k == 4'd14) begin
            k   <= '0;
            col <= '0;
            row <= '0;
            if (nxt == count) begin
              state <= FINISH;
            end else begin
              glyph <= nxt[AW-1:0];
              xbase <= xbase + 8'(CHAR_PITCH);
              state <= READ;
            end
          end else begin
            k <= k + 4'd1;
            if (col == 2'd2) begin
              col <= '0;
              row <= row + 3'd1;
            end else begin
              col <= col + 2'd1;
            end
          end
        end
        FINISH: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_draw_controller.sv
// Directed bench for text_draw_controller with a sync RAM and glyph table.
// Cycle 0 is the cycle in which start is sampled.
module tb_text_draw_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] origin_x = '0;
  logic [6:0] origin_y = '0;
  logic [4:0] num_chars = '0;
  logic [2:0] colour = '0;
  logic [3:0] buf_addr;
  logic [5:0] buf_code;
  logic [5:0] pat_code;
  logic [0:14] pat_bits;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour_out;
  logic       plot, busy, done;

  logic [5:0] mem [0:15];
  int checks = 0;
  int errors = 0;

  logic [7:0] px [0:299];
  logic [6:0] py [0:299];
  logic [2:0] pc [0:299];
  logic [5:0] pa [0:299];
  logic [3:0] ba [0:299];
  logic       pl [0:299];
  logic       dn [0:299];
  logic       bz [0:299];

  text_draw_controller dut (
    .clk(clk), .reset(reset), .start(start),
    .origin_x(origin_x), .origin_y(origin_y),
    .num_chars(num_chars), .colour(colour),
    .buf_addr(buf_addr), .buf_code(buf_code),
    .pat_code(pat_code), .pat_bits(pat_bits),
    .x(x), .y(y), .colour_out(colour_out),
    .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) buf_code <= mem[buf_addr];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [0:14] enc(input logic [5:0] c);
    case (c)
      6'd1:    enc = 15'b111_101_101_101_111;
      6'd9:    enc = 15'b111_101_111_101_111;
      6'd11:   enc = 15'b010_101_111_101_101;
      6'd30:   enc = 15'b111_010_010_010_010;
      default: enc = '0;
    endcase
  endfunction

  always_comb pat_bits = enc(pat_code);

  function automatic logic ep(input logic lit);
`ifdef TEXT_TRANSPARENT_EN
    return lit;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [2:0] ec(input logic lit, input logic [2:0] fg);
`ifdef TEXT_TRANSPARENT_EN
    return fg;
`else
    return lit ? fg : 3'b000;
`endif
  endfunction

  function automatic int ecount(input logic [5:0] code);
    logic [0:14] p;
    int n;
    p = enc(code);
    n = 0;
    for (int k = 0; k < 15; k++) n += int'(ep(p[k]));
    return n;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [7:0] ox, input logic [6:0] oy,
                        input logic [4:0] n, input logic [2:0] fg);
    origin_x  = ox;
    origin_y  = oy;
    num_chars = n;
    colour    = fg;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic record(input int len, input int rp, input int rc);
    for (int c = 0; c < 300; c++) begin
      px[c] = '0; py[c] = '0; pc[c] = '0; pa[c] = '0;
      ba[c] = '0; pl[c] = 1'b0; dn[c] = 1'b0; bz[c] = 1'b0;
    end
    for (int c = 1; c <= len; c++) begin
      px[c] = x; py[c] = y; pc[c] = colour_out; pa[c] = pat_code;
      ba[c] = buf_addr; pl[c] = plot; dn[c] = done; bz[c] = busy;
      if (c == rp) begin
        start = 1'b1; origin_x = 8'd99; origin_y = 7'd99;
        colour = 3'b011; num_chars = 5'd3;
      end
      if (c == rc) reset = 1'b0;
      step();
      start = 1'b0;
      reset = 1'b1;
    end
  endtask

  function automatic int nplots(input int len);
    int n = 0;
    for (int c = 1; c <= len; c++) n += int'(pl[c]);
    return n;
  endfunction

  function automatic int ndone(input int len);
    int n = 0;
    for (int c = 1; c <= len; c++) n += int'(dn[c]);
    return n;
  endfunction

  task automatic check_cell(input string tag, input int c0, input int g,
                            input logic [7:0] x0, input logic [6:0] y0,
                            input logic [5:0] code, input logic [2:0] fg);
    logic [0:14] p;
    p = enc(code);
    for (int k = 0; k < 15; k++) begin
      int c;
      logic [7:0] ex;
      logic [6:0] ey;
      c  = c0 + k;
      ex = x0 + 8'(g * 4 + k % 3);
      ey = y0 + 7'(k / 3);
      if (ep(p[k]))
        chk(tag, {pl[c], px[c], py[c], pc[c]}, {1'b1, ex, ey, ec(p[k], fg)});
      else
        chk(tag, pl[c], 1'b0);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 6'd0;
    reset = 1'b0;
    step(); step(); step();
    chk("reset", {x, y, colour_out, plot, busy, done, buf_addr, pat_code}, 31'd0);
    reset = 1'b1;
    step();

    mem[0] = 6'd1;
    launch(8'd10, 7'd20, 5'd1, 3'b100);
    record(21, 0, 0);
    check_cell("g0_px", 4, 0, 8'd10, 7'd20, 6'd1, 3'b100);
    chk("g0_nplot", nplots(21), ecount(6'd1));
    chk("g0_done19", {dn[18], dn[19], dn[20]}, 3'b010);
    chk("g0_ndone", ndone(21), 1);
    for (int c = 1; c <= 21; c++)
      chk("g0_busy", bz[c], (c <= 18) ? 1'b1 : 1'b0);
`ifndef TEXT_TRANSPARENT_EN
    chk("g0_hole", {px[8], py[8], pc[8]}, {8'd11, 7'd21, 3'b000});
`endif

    mem[0] = 6'd11;
    mem[1] = 6'd30;
    launch(8'd0, 7'd0, 5'd2, 3'b111);
    record(38, 0, 0);
    check_cell("at_a", 4, 0, 8'd0, 7'd0, 6'd11, 3'b111);
    check_cell("at_t", 21, 1, 8'd0, 7'd0, 6'd30, 3'b111);
    chk("at_gap", {pl[19], pl[20]}, 2'b00);
    chk("at_t50", {px[22], py[22], pc[22]}, {8'd5, 7'd0, 3'b111});
`ifdef TEXT_TRANSPARENT_EN
    chk("at_t41", pl[24], 1'b0);
`else
    chk("at_t41", {px[24], py[24], pc[24]}, {8'd4, 7'd1, 3'b000});
`endif
    chk("at_done36", {dn[35], dn[36], dn[37]}, 3'b010);
    chk("at_ndone", ndone(38), 1);

    launch(8'd5, 7'd5, 5'd0, 3'b001);
    record(6, 0, 0);
    chk("z_done", {dn[1], dn[2], dn[3], dn[4]}, 4'b0100);
    chk("z_busy", {bz[1], bz[2], bz[3], bz[4]}, 4'b1000);
    chk("z_nplot", nplots(6), 0);

    for (int i = 0; i < 16; i++) mem[i] = 6'd9;
    launch(8'd0, 7'd0, 5'd20, 3'b001);
    record(276, 0, 0);
    chk("cl_nplot", nplots(276), 16 * ecount(6'd9));
    chk("cl_done", {dn[273], dn[274], dn[275]}, 3'b010);
    chk("cl_ndone", ndone(276), 1);
    chk("cl_busy", {bz[273], bz[274]}, 2'b10);
    chk("cl_last", {px[273], py[273], ba[273]}, {8'd62, 7'd4, 4'd15});

    mem[0] = 6'd1;
    launch(8'd10, 7'd20, 5'd1, 3'b100);
    record(25, 10, 0);
    check_cell("rp_px", 4, 0, 8'd10, 7'd20, 6'd1, 3'b100);
    chk("rp_nplot", nplots(25), ecount(6'd1));
    chk("rp_done", {dn[19], ndone(25)}, {1'b1, 32'd1});
    chk("rp_idle", {bz[20], bz[25]}, 2'b00);

    launch(8'd10, 7'd20, 5'd1, 3'b100);
    record(12, 0, 8);
    chk("rs_pre", pl[8], 1'b1);
    chk("rs_zero", {px[9], py[9], pc[9], pl[9], bz[9], dn[9], ba[9], pa[9]}, 31'd0);
    chk("rs_ndone", ndone(12), 0);
    chk("rs_nplot", nplots(12) - int'(pl[4]) - int'(pl[5]) - int'(pl[6]) - int'(pl[7]) - int'(pl[8]), 0);
    launch(8'd10, 7'd20, 5'd1, 3'b100);
    record(21, 0, 0);
    check_cell("rs_px", 4, 0, 8'd10, 7'd20, 6'd1, 3'b100);
    chk("rs_done", {dn[19], ndone(21)}, {1'b1, 32'd1});

    mem[0] = 6'd9;
    launch(8'd254, 7'd126, 5'd1, 3'b010);
    record(21, 0, 0);
    check_cell("wr_px", 4, 0, 8'd254, 7'd126, 6'd9, 3'b010);
    chk("wr_x", {px[4], px[5], px[6]}, {8'd254, 8'd255, 8'd0});
    chk("wr_y", {py[4], py[7], py[10], py[13], py[16]}, {7'd126, 7'd127, 7'd0, 7'd1, 7'd2});
    chk("wr_nplot", nplots(21), ecount(6'd9));
    chk("wr_done", dn[19], 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_draw_controller.md
Name: text_draw_controller

Overview:
- Sequencer that renders a string of 3x5 glyphs into the VGA pixel plotter.
- Reads 6-bit letter codes from a character buffer and drives each code into the glyph pattern encoder (letterCode -> 15-bit pixelPattern, row-major, MSB index 0 = top-left).
- Walks the 15 pixels of each glyph and emits one x/y/colour/plot write per cycle to the VGA adapter.
- Sits between the text buffer, the pattern encoder and the VGA adapter; start/busy/done handshake toward the top-level game FSM.

Parameters:
- MAX_CHARS, 16: maximum glyphs per draw command; buffer address width is clog2(MAX_CHARS).
- CHAR_PITCH, 4: horizontal pixel step between glyph origins (3 glyph columns + 1 gap).
- BG_COLOUR, 3'b000: colour written for unlit glyph pixels.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  draw command request; single-cycle pulse or level.
- origin_x  in  8  x of top-left pixel of glyph 0.
- origin_y  in  7  y of top-left pixel of glyph 0.
- num_chars  in  clog2(MAX_CHARS)+1  glyph count for this command.
- colour  in  3  foreground colour for lit pixels.
- buf_addr  out  clog2(MAX_CHARS)  character buffer read address.
- buf_code  in  6  buffer read data; valid one cycle after buf_addr (synchronous RAM).
- pat_code  out  6  letter code driven to the pattern encoder (registered).
- pat_bits  in  15 [0:14]  encoder output; combinational from pat_code.
- x  out  8  plot x.
- y  out  7  plot y.
- colour_out  out  3  plot colour.
- plot  out  1  pixel write strobe.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: clk edge with reset=0 forces IDLE. x, y, colour_out, plot, busy, done, buf_addr and pat_code all go to 0. Glyph index and pixel index clear. Applies mid-command with no done pulse.
- Command capture: in IDLE with start=1, origin_x, origin_y, colour and num_chars are captured. num_chars > MAX_CHARS is clamped to MAX_CHARS. start outside IDLE is ignored.
- States:
  - IDLE: waiting for start.
  - READ: buf_addr = glyph index.
  - LATCH: pat_code <= buf_code.
  - DRAW: 15 cycles, pixel index k = 0..14.
  - FINISH.
- Transitions:
  - IDLE -> READ on start when captured count > 0.
  - IDLE -> FINISH on start when count = 0.
  - READ -> LATCH -> DRAW.
  - DRAW at k=14: -> READ with glyph index+1 if more glyphs remain, else -> FINISH.
  - FINISH -> IDLE.
- Pixel math in DRAW cycle k:
  - row = k/3, col = k%3.
  - x <= origin_x + glyph*CHAR_PITCH + col, modulo 256.
  - y <= origin_y + row, modulo 128.
  - colour_out <= pat_bits[k] ? colour : BG_COLOUR.
  - plot <= 1.
  - Outputs are registered and appear the cycle after the DRAW cycle.
- plot = 0 in every cycle not following a DRAW cycle.
- Timing (cycle 0 = cycle in which start is sampled):
  - Glyph g uses READ at 17g+1, LATCH at 17g+2, DRAW at 17g+3 .. 17g+17.
  - Plots for glyph g are visible at 17g+4 .. 17g+18.
  - busy = 1 from cycle 1 through cycle 17N+1.
  - FINISH state at 17N+1.
  - done = 1 only in cycle 17N+2, busy = 0 in that same cycle.
  - A start sampled in cycle 17N+2 is accepted.
- Count 0: done = 1 in cycle 2, busy = 1 only in cycle 1, no plots.
- Unknown or blank code (encoder returns all zeros): the glyph cell is still swept and written with BG_COLOUR.

Optional Feature:
- Macro: TEXT_TRANSPARENT_EN.
- Defined: in DRAW, plot <= pat_bits[k]. Unlit pixels are not written, so underlying graphics show through. colour_out = colour whenever plot = 1. Cycle timing is unchanged.
- Undefined: behaviour exactly as in Behaviour above; all 15 pixels are written.

Test Plan:
- Glyph '0': buffer[0]=6'd1, origin (10,20), colour 3'b100, N=1.
  - Expect 15 plots at cycles 4..18: x 10,11,12 repeating, y 20..24.
  - Pixel (11,21..23) gets 3'b000; all other pixels get 3'b100.
  - done at cycle 19.
- Two glyphs: buffer = {6'd11 'A', 6'd30 'T'}, origin (0,0).
  - Glyph 1 plots at x 4..6 during cycles 21..35, with plot=0 in cycles 19,20.
  - Pixel (5,0) is 3'b111; pixel (4,1) is BG.
  - done at cycle 36.
- num_chars=0:
  - done at cycle 2, no plot ever asserted.
  - num_chars=20 with MAX_CHARS=16: exactly 16*15 plots, done at cycle 274.
- start re-pulsed at cycle 10 of an N=1 command: ignored; single done at cycle 19; capture values unchanged.
- reset=0 at cycle 8 mid-DRAW:
  - Next cycle all outputs are 0 and state is IDLE; no done.
  - A new start then completes normally.
- Wrap: origin (254,126), N=1, code 6'd9.
  - x sequence 254,255,0; y 126,127,0,1,2.
  - With TEXT_TRANSPARENT_EN: only the 13 lit pixels plot.
